// File: rtl/pe_pkg.sv
// Shared widths and types for the processing-element accumulator.
// Optional drop flag acc_err is enabled by defining PE_ACC_ERR_EN.
package pe_pkg;
    localparam int ACC_W          = 24;
    localparam int LEN_W          = 8;
    localparam int PROD_W         = 16;
    localparam int RES_FIFO_DEPTH = 2;

    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [PROD_W-1:0] prod_t;

    function automatic acc_t widen(prod_t p);
        return {{(ACC_W-PROD_W){1'b0}}, p};
    endfunction
endpackage

// File: rtl/pe_acc_fifo.sv
// Small result queue between the accumulator and its consumer.
// A push while full is taken only if a pop frees a slot in the same cycle.
module pe_acc_fifo
    import pe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push,
    input  acc_t push_data,
    input  logic pop,
    output acc_t pop_data,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(RES_FIFO_DEPTH);

    acc_t             mem [RES_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(RES_FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RES_FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pe_acc.sv
// Accumulates groups of K products from a PE and queues each group sum.
// Define PE_ACC_ERR_EN to expose the sticky drop flag acc_err.
module pe_acc
    import pe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        c1_vld,
    input  logic [15:0] c1_data,
    input  logic [7:0]  acc_len,
    input  logic        acc_clr,
    output logic        res_vld,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        acc_busy
`ifdef PE_ACC_ERR_EN
    ,
    output logic        acc_err
`endif
);
    len_t cnt;
    len_t klat;
    len_t k_cur;
    acc_t sum;
    acc_t sum_next;
    logic last;
    logic push_acc;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    // K is taken live from acc_len only on the first product of a group;
    // K-1 wraps to 255 when the length is 0, giving 256-product groups.
    always_comb begin
        k_cur    = (cnt == '0) ? acc_len : klat;
        sum_next = (cnt == '0) ? widen(c1_data) : sum + widen(c1_data);
        last     = (cnt == len_t'(k_cur - 1'b1));
    end

    assign push_acc  = c1_vld && !acc_clr && last;
    assign fifo_pop  = res_ready && !fifo_empty;
    assign fifo_push = push_acc && (!fifo_full || fifo_pop);
    assign res_vld   = !fifo_empty;
    assign acc_busy  = (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sum  <= '0;
            klat <= '0;
        end else if (acc_clr) begin
            cnt <= '0;
            sum <= '0;
        end else if (c1_vld) begin
            if (cnt == '0) klat <= acc_len;
            if (last) begin
                cnt <= '0;
            end else begin
                sum <= sum_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef PE_ACC_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           acc_err <= 1'b0;
        else if (acc_clr)                  acc_err <= 1'b0;
        else if (push_acc && !fifo_push)   acc_err <= 1'b1;
    end
`endif

    pe_acc_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .push      (fifo_push),
        .push_data (sum_next),
        .pop       (fifo_pop),
        .pop_data  (res_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_pe_acc.sv
// Directed bench for pe_acc with hand-computed expected results.
// Build with PE_ACC_ERR_EN defined to also check acc_err.
module tb_pe_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        c1_vld;
    logic [15:0] c1_data;
    logic [7:0]  acc_len;
    logic        acc_clr;
    logic        res_vld;
    logic        res_ready;
    logic [23:0] res_data;
    logic        acc_busy;
`ifdef PE_ACC_ERR_EN
    logic        acc_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_acc dut (
        .clk       (clk),
        .rst       (rst),
        .c1_vld    (c1_vld),
        .c1_data   (c1_data),
        .acc_len   (acc_len),
        .acc_clr   (acc_clr),
        .res_vld   (res_vld),
        .res_ready (res_ready),
        .res_data  (res_data),
        .acc_busy  (acc_busy)
`ifdef PE_ACC_ERR_EN
        ,
        .acc_err   (acc_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        @(negedge clk);
        c1_vld  = v;
        c1_data = d;
    endtask

    initial begin
        rst       = 1'b1;
        c1_vld    = 1'b0;
        c1_data   = '0;
        acc_len   = '0;
        acc_clr   = 1'b0;
        res_ready = 1'b1;
        #12;
        chk("rst_vld", 32'(res_vld), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_busy", 32'(acc_busy), 0);
`ifdef PE_ACC_ERR_EN
        chk("rst_err", 32'(acc_err), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // K=4, products 1..4; acc_len change mid-group must be ignored
        acc_len = 8'd4;
        drive(1'b1, 16'd1);
        drive(1'b1, 16'd2);
        acc_len = 8'd2;
        chk("k4_busy1", 32'(acc_busy), 1);
        drive(1'b1, 16'd3);
        chk("k4_busy2", 32'(acc_busy), 1);
        chk("k4_novld2", 32'(res_vld), 0);
        drive(1'b1, 16'd4);
        chk("k4_busy3", 32'(acc_busy), 1);
        chk("k4_novld3", 32'(res_vld), 0);
        drive(1'b0, 16'd0);
        chk("k4_vld", 32'(res_vld), 1);
        chk("k4_data", 32'(res_data), 10);
        chk("k4_idle", 32'(acc_busy), 0);
        @(negedge clk);
        chk("k4_popped", 32'(res_vld), 0);

        // K=1, max product
        acc_len = 8'd1;
        drive(1'b1, 16'd65025);
        chk("k1_busy", 32'(acc_busy), 0);
        drive(1'b0, 16'd0);
        chk("k1_vld", 32'(res_vld), 1);
        chk("k1_data", 32'(res_data), 65025);
        chk("k1_busy2", 32'(acc_busy), 0);

        // K=256 (acc_len=0), all max products
        acc_len = 8'd0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 16'd65025);
            if (i == 255) begin
                chk("k256_busy", 32'(acc_busy), 1);
                chk("k256_novld", 32'(res_vld), 0);
            end
        end
        drive(1'b0, 16'd0);
        chk("k256_vld", 32'(res_vld), 1);
        chk("k256_data", 32'(res_data), 32'hFE0100);
        @(negedge clk);
        chk("k256_single", 32'(res_vld), 0);

        // Overflow: FIFO holds 5,6; 7 is dropped
        acc_len   = 8'd1;
        res_ready = 1'b0;
        drive(1'b1, 16'd5);
        drive(1'b1, 16'd6);
        drive(1'b1, 16'd7);
        drive(1'b0, 16'd0);
        chk("ovf_vld", 32'(res_vld), 1);
        chk("ovf_head", 32'(res_data), 5);
        @(negedge clk);
        chk("ovf_hold", 32'(res_data), 5);
`ifdef PE_ACC_ERR_EN
        chk("ovf_err", 32'(acc_err), 1);
`endif
        res_ready = 1'b1;
        @(negedge clk);
        chk("ovf_second", 32'(res_data), 6);
        chk("ovf_vld2", 32'(res_vld), 1);
        @(negedge clk);
        chk("ovf_empty", 32'(res_vld), 0);
`ifdef PE_ACC_ERR_EN
        chk("ovf_sticky", 32'(acc_err), 1);
`endif

        // Abort a partial group with acc_clr
        acc_len = 8'd4;
        drive(1'b1, 16'd9);
        drive(1'b1, 16'd9);
        drive(1'b1, 16'd100);
        acc_clr = 1'b1;
        drive(1'b0, 16'd0);
        acc_clr = 1'b0;
        chk("clr_busy", 32'(acc_busy), 0);
        chk("clr_vld", 32'(res_vld), 0);
`ifdef PE_ACC_ERR_EN
        chk("clr_err", 32'(acc_err), 0);
`endif
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd3);
        drive(1'b0, 16'd0);
        chk("clr_vld2", 32'(res_vld), 1);
        chk("clr_data", 32'(res_data), 12);

        // Abort a partial group with rst
        drive(1'b1, 16'd50);
        drive(1'b1, 16'd50);
        drive(1'b0, 16'd0);
        rst = 1'b1;
        #2;
        chk("rstmid_busy", 32'(acc_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        acc_len = 8'd4;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd3);
        drive(1'b0, 16'd0);
        chk("rstmid_data", 32'(res_data), 12);
        @(negedge clk);

        // Full FIFO with simultaneous push and pop
        acc_len   = 8'd1;
        res_ready = 1'b0;
        drive(1'b1, 16'd11);
        drive(1'b1, 16'd22);
        drive(1'b1, 16'd33);
        chk("pp_head", 32'(res_data), 11);
        res_ready = 1'b1;
        drive(1'b0, 16'd0);
        chk("pp_second", 32'(res_data), 22);
        @(negedge clk);
        chk("pp_third", 32'(res_data), 33);
        chk("pp_vld3", 32'(res_vld), 1);
        @(negedge clk);
        chk("pp_empty", 32'(res_vld), 0);
`ifdef PE_ACC_ERR_EN
        chk("pp_err", 32'(acc_err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
